// File: rtl/i2c_reg_sequencer.sv
// I2C byte -> 6-bit register bus sequencer: ADDR/DATA/CLRERR decode, read-back, ACK timeout.
// Define PIF_PTR_AUTOINC_EN to auto-increment the pointer after every acked access.
module i2c_reg_sequencer #(
  parameter int DATA_BITS = 6,
  parameter int TIMEOUT   = 255,
  parameter int PTR_RESET = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_rx_ready,
  input  logic                 i_rx_stop,
  input  logic                 i_tx_req,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  output logic [DATA_BITS-1:0] o_reg_addr,
  output logic [DATA_BITS-1:0] o_reg_wdata,
  output logic                 o_reg_we,
  output logic                 o_reg_re,
  input  logic [DATA_BITS-1:0] i_reg_rdata,
  input  logic                 i_reg_ack,
  output logic                 o_busy,
  output logic                 o_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_TXOUT
  } state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [DATA_BITS-1:0] PTR_INIT = DATA_BITS'(PTR_RESET);

  localparam logic [1:0] OP_ADDR = 2'b00;
  localparam logic [1:0] OP_DATA = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_run;
  logic [DATA_BITS-1:0] r_ptr;
  logic [DATA_BITS-1:0] w_ptr_nxt;
  logic [DATA_BITS-1:0] r_wdata;
  logic [DATA_BITS-1:0] w_wdata_nxt;
  logic [7:0]           r_tx_data;
  logic [7:0]           w_tx_data_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic                 r_err;
  logic                 w_err_nxt;

  logic [1:0]           w_op;
  logic [DATA_BITS-1:0] w_payload;
  logic                 w_idle;
  logic                 w_rx_fire;
  logic                 w_timeout;
  logic [DATA_BITS-1:0] w_ptr_inc;
  logic                 w_unused;

  // STOP carries no action: pointer is kept and in-flight accesses finish.
  assign w_unused  = i_rx_stop;

  assign w_op      = i_rx_data[7:6];
  assign w_payload = i_rx_data[DATA_BITS-1:0];
  assign w_idle    = (r_state == S_IDLE);
  assign w_rx_fire = r_run & w_idle & i_rx_valid;
  assign w_timeout = (r_cnt == CNT_LAST);

`ifdef PIF_PTR_AUTOINC_EN
  assign w_ptr_inc = r_ptr + 1'b1;
`else
  assign w_ptr_inc = r_ptr;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_run     <= 1'b0;
      r_ptr     <= PTR_INIT;
      r_wdata   <= '0;
      r_tx_data <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_run     <= 1'b1;
      r_ptr     <= w_ptr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_cnt     <= w_cnt_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_wdata_nxt   = r_wdata;
    w_tx_data_nxt = r_tx_data;
    w_cnt_nxt     = r_cnt;
    w_err_nxt     = r_err;
    unique case (r_state)
      S_IDLE: begin
        // An RX byte takes priority; a pending TX_REQ waits one more IDLE cycle.
        if (w_rx_fire) begin
          unique case (1'b1)
            (w_op == OP_ADDR): w_ptr_nxt = w_payload;
            (w_op == OP_DATA): begin
              w_wdata_nxt = w_payload;
              w_cnt_nxt   = '0;
              w_state_nxt = S_WRITE;
            end
            (w_op == OP_CLR): w_err_nxt = 1'b0;
            default: w_err_nxt = 1'b1;
          endcase
        end else if (r_run && i_tx_req) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_READ;
        end
      end
      S_WRITE: begin
        if (i_reg_ack) begin
          w_ptr_nxt   = w_ptr_inc;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_READ: begin
        // A timed-out read still answers the slave, with 8'hFF.
        if (i_reg_ack) begin
          w_tx_data_nxt = {2'b01, i_reg_rdata};
          w_ptr_nxt     = w_ptr_inc;
          w_state_nxt   = S_TXOUT;
        end else if (w_timeout) begin
          w_tx_data_nxt = 8'hFF;
          w_err_nxt     = 1'b1;
          w_state_nxt   = S_TXOUT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_TXOUT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_rx_ready  = r_run & w_idle;
  assign o_busy      = ~w_idle;
  assign o_reg_we    = (r_state == S_WRITE);
  assign o_reg_re    = (r_state == S_READ);
  assign o_tx_valid  = (r_state == S_TXOUT);
  assign o_tx_data   = r_tx_data;
  assign o_reg_addr  = r_ptr;
  assign o_reg_wdata = r_wdata;
  assign o_err       = r_err;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: byte table plus read / arbitration / timeout / reset sequences.
module tb_i2c_reg_sequencer;

`ifdef PIF_PTR_AUTOINC_EN
  localparam bit A = 1'b1;
`else
  localparam bit A = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_stop;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [5:0] reg_addr;
  logic [5:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [5:0] reg_rdata;
  logic       reg_ack;
  logic       busy;
  logic       err;

  i2c_reg_sequencer #(
    .DATA_BITS(6),
    .TIMEOUT  (8),
    .PTR_RESET(0)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .i_rx_stop  (rx_stop),
    .i_tx_req   (tx_req),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .o_reg_addr (reg_addr),
    .o_reg_wdata(reg_wdata),
    .o_reg_we   (reg_we),
    .o_reg_re   (reg_re),
    .i_reg_rdata(reg_rdata),
    .i_reg_ack  (reg_ack),
    .o_busy     (busy),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int g_ack_dly = 1;
  int g_we_len = 0;

  typedef struct packed {
    logic [5:0] a;
    logic [5:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [5:0] rq[$];
  logic [7:0] txq[$];

  typedef struct {
    logic [7:0] b;
    int         dly;
    bit         we;
    logic [5:0] addr;
    logic [5:0] wd;
    int         len;
    logic [5:0] ptr;
    bit         err;
  } vec_t;

  vec_t v[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] pa(input int a, input int n);
    return A ? 6'(a) : 6'(n);
  endfunction

  // Register-bus responder: ack g_ack_dly cycles after strobe, 0 = never.
  initial begin : responder
    int cnt;
    cnt = 0;
    reg_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reg_ack) begin
        reg_ack = 1'b0;
        cnt = 0;
      end else if ((reg_we || reg_re) && g_ack_dly > 0) begin
        cnt++;
        if (cnt >= g_ack_dly) reg_ack = 1'b1;
      end else if (!(reg_we || reg_re)) begin
        cnt = 0;
      end
    end
  end

  // Scoreboard: pop expected accesses / TX bytes as the DUT produces them.
  initial begin : monitor
    logic pwe, pre;
    int   wl;
    pwe = 1'b0;
    pre = 1'b0;
    wl = 0;
    forever begin
      @(negedge clk);
      if (reg_we && !pwe) begin
        if (wq.size() == 0) chk("unexp_we", 1, 0);
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", reg_addr, e.a);
          chk("wr_data", reg_wdata, e.d);
        end
      end
      if (reg_re && !pre) begin
        if (rq.size() == 0) chk("unexp_re", 1, 0);
        else chk("rd_addr", reg_addr, rq.pop_front());
      end
      if (tx_valid) begin
        if (txq.size() == 0) chk("unexp_txv", 1, 0);
        else chk("tx_data", tx_data, txq.pop_front());
      end
      if (reg_we) wl++;
      else if (pwe) begin
        g_we_len = wl;
        wl = 0;
      end
      pwe = reg_we;
      pre = reg_re;
    end
  end

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("rx_ready_wait", 0, 1);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("idle_wait", 1, 0);
    #1;
  endtask

  task automatic wait_txv();
    int t;
    t = 0;
    while (!tx_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("tx_valid_wait", 0, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    rst = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    rx_stop = 1'b0;
    tx_req = 1'b0;
    reg_rdata = 6'h00;

    v[0]  = '{8'h02, 2, 0, 6'd0,        6'd0,  0, 6'd2,            0};
    v[1]  = '{8'h41, 2, 1, 6'd2,        6'd1,  2, pa(3, 2),        0};
    v[2]  = '{8'h05, 1, 0, 6'd0,        6'd0,  0, 6'd5,            0};
    v[3]  = '{8'h43, 1, 1, 6'd5,        6'd3,  1, pa(6, 5),        0};
    v[4]  = '{8'h47, 3, 1, pa(6, 5),    6'd7,  3, pa(7, 5),        0};
    v[5]  = '{8'hC0, 1, 0, 6'd0,        6'd0,  0, pa(7, 5),        1};
    v[6]  = '{8'h80, 1, 0, 6'd0,        6'd0,  0, pa(7, 5),        0};
    v[7]  = '{8'h3F, 1, 0, 6'd0,        6'd0,  0, 6'd63,           0};
    v[8]  = '{8'h49, 1, 1, 6'd63,       6'd9,  1, pa(0, 63),       0};
    v[9]  = '{8'h7F, 8, 1, pa(0, 63),   6'd63, 8, pa(1, 63),       0};
    v[10] = '{8'h55, 0, 1, pa(1, 63),   6'd21, 8, pa(1, 63),       1};
    v[11] = '{8'h80, 1, 0, 6'd0,        6'd0,  0, pa(1, 63),       0};
    v[12] = '{8'h56, 1, 1, pa(1, 63),   6'd22, 1, pa(2, 63),       0};

    repeat (2) @(negedge clk);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_re", reg_re, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ptr", reg_addr, 0);
    rst = 1'b0;
    #1 chk("rel_rx_ready0", rx_ready, 0);
    @(negedge clk);
    chk("rel_rx_ready1", rx_ready, 1);

    for (int i = 0; i < 13; i++) begin
      g_ack_dly = v[i].dly;
      if (v[i].we) wq.push_back(wr_t'{a: v[i].addr, d: v[i].wd});
      send(v[i].b);
      chk($sformatf("r%0d_we_lat", i), reg_we, v[i].we);
      wait_idle();
      if (v[i].we) chk($sformatf("r%0d_we_len", i), g_we_len, v[i].len);
      chk($sformatf("r%0d_ptr", i), reg_addr, v[i].ptr);
      chk($sformatf("r%0d_err", i), err, v[i].err);
    end

    // Write at 63 then read: pointer wraps to 0 with auto-increment.
    g_ack_dly = 1;
    send(8'h3F);
    wq.push_back(wr_t'{a: 6'd63, d: 6'd9});
    send(8'h49);
    wait_idle();
    g_ack_dly = 2;
    reg_rdata = 6'h2A;
    rq.push_back(pa(0, 63));
    txq.push_back(8'h6A);
    tx_req = 1'b1;
    wait_txv();
    tx_req = 1'b0;
    @(negedge clk);
    chk("h1_txv_1cyc", tx_valid, 0);
    wait_idle();
    chk("h1_ptr", reg_addr, pa(1, 63));
    chk("h1_err", err, 0);

    // RX byte and TX_REQ together: write first, then read.
    g_ack_dly = 1;
    reg_rdata = 6'h15;
    wq.push_back(wr_t'{a: pa(1, 63), d: 6'd12});
    rq.push_back(pa(2, 63));
    txq.push_back(8'h55);
    rx_data = 8'h4C;
    rx_valid = 1'b1;
    tx_req = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("h2_we_first", reg_we, 1);
    chk("h2_re_later", reg_re, 0);
    wait_txv();
    tx_req = 1'b0;
    wait_idle();
    chk("h2_ptr", reg_addr, pa(3, 63));
    send(8'hC0);
    chk("h2_rsv_we", reg_we, 0);
    chk("h2_rsv_re", reg_re, 0);
    chk("h2_rsv_busy", busy, 0);
    chk("h2_rsv_err", err, 1);
    send(8'h80);
    #1 chk("h2_clr_err", err, 0);

    // Read with no ACK: FF returned, error set, pointer held.
    g_ack_dly = 0;
    rq.push_back(pa(3, 63));
    txq.push_back(8'hFF);
    tx_req = 1'b1;
    wait_txv();
    tx_req = 1'b0;
    wait_idle();
    chk("h3_err", err, 1);
    chk("h3_ptr", reg_addr, pa(3, 63));
    send(8'h80);

    // Reset in the middle of a read.
    rq.push_back(pa(3, 63));
    tx_req = 1'b1;
    begin
      int t;
      t = 0;
      while (!reg_re && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) chk("h4_re_wait", 0, 1);
    end
    rst = 1'b1;
    #1;
    chk("h4_re_drop", reg_re, 0);
    chk("h4_busy", busy, 0);
    chk("h4_ptr", reg_addr, 0);
    chk("h4_txv", tx_valid, 0);
    chk("h4_rx_ready", rx_ready, 0);
    tx_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("h4_rel_ready0", rx_ready, 0);
    @(negedge clk);
    chk("h4_rel_ready1", rx_ready, 1);
    chk("h4_err", err, 0);
    repeat (3) @(negedge clk);

    chk("q_wr_left", wq.size(), 0);
    chk("q_rd_left", rq.size(), 0);
    chk("q_tx_left", txq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
